// File: rtl/ir_registers_alu_pkg.sv
// Shared encodings for the IR / register-file / ALU datapath slice.
package ir_registers_alu_pkg;

    localparam int WORD_W = 32;
    localparam int NREGS  = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_OR   = 3'b111
    } alu_cmd_e;

    typedef enum logic [1:0] {
        DST_RD     = 2'b00,
        DST_RT     = 2'b01,
        DST_R31    = 2'b10,
        DST_RD_ALT = 2'b11
    } dst_sel_e;

    typedef enum logic {
        ALUA_PC    = 1'b0,
        ALUA_LATCH = 1'b1
    } alua_sel_e;

    typedef enum logic [1:0] {
        ALUB_IMM      = 2'b00,
        ALUB_LATCH    = 2'b01,
        ALUB_FOUR     = 2'b10,
        ALUB_FOUR_ALT = 2'b11
    } alub_sel_e;

    localparam logic [RADDR_W-1:0] REG_LINK   = 5'd31;
    localparam logic [WORD_W-1:0]  CONST_FOUR = 32'd4;

    function automatic logic signed [WORD_W-1:0] sign_ext16(input logic [15:0] imm);
        return {{(WORD_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ir_registers_alu_if.sv
// Control/data bundle between the sequencer (master) and the datapath (slave).
interface ir_registers_alu_if;
    import ir_registers_alu_pkg::*;

    logic [WORD_W-1:0] instr_in;
    logic              ir_we;
    logic [WORD_W-1:0] Dw;
    logic              WrEn;
    logic [WORD_W-1:0] pc_in;
    logic [1:0]        control_signalDST;
    logic              control_signalALUa;
    logic [1:0]        control_signalALUb;
    logic [2:0]        command;
    logic [WORD_W-1:0] ALU_out;
    logic              zero;

    modport master (
        output instr_in, ir_we, Dw, WrEn, pc_in,
        output control_signalDST, control_signalALUa, control_signalALUb, command,
        input  ALU_out, zero
    );

    modport slave (
        input  instr_in, ir_we, Dw, WrEn, pc_in,
        input  control_signalDST, control_signalALUa, control_signalALUb, command,
        output ALU_out, zero
    );

endinterface

// File: rtl/ir_registers_alu_alu.sv
// Combinational 32-bit ALU: add/sub/logic ops and overflow-safe signed compare.
module alu
    import ir_registers_alu_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  alu_cmd_e                 cmd,
    output logic        [DATA_W-1:0] result,
    output logic                     zero
);

    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              ovf;
    logic              lt;

    // SLT reuses the subtractor; sign of the difference is corrected by overflow
    always_comb begin
        is_sub       = (cmd == ALU_SUB) || (cmd == ALU_SLT);
        b_eff        = is_sub ? ~b : b;
        {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
        ovf          = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        lt           = sum[DATA_W-1] ^ ovf;
    end

    always_comb begin
        result = '0;
        unique case (cmd)
            ALU_ADD:  result = sum;
            ALU_SUB:  result = sum;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, lt};
            ALU_AND:  result = a & b;
            ALU_NAND: result = ~(a & b);
            ALU_NOR:  result = ~(a | b);
            ALU_OR:   result = a | b;
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

    // For equal-sign operands the signed and unsigned orderings agree (borrow = ~carry)
    always_comb begin
        if (cmd == ALU_SLT && a[DATA_W-1] == b[DATA_W-1])
            assert (lt == ~carry);
    end

endmodule

// File: rtl/ir_registers_alu.sv
// Instruction register, 32x32 register file, A/B operand latches, source muxes and ALU.
module ir_registers_alu
    import ir_registers_alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ir_registers_alu_if.slave  bus
);

    logic [WORD_W-1:0]        ir_q;
    logic [RADDR_W-1:0]       rs, rt, rd, wr_addr;
    logic [15:0]              imm16;
    logic [WORD_W-1:0]        regs [NREGS];
    logic [WORD_W-1:0]        da, db;
    logic signed [WORD_W-1:0] a_p1, b_p1;
    logic signed [WORD_W-1:0] src_a, src_b;
    logic [WORD_W-1:0]        alu_res;
    logic                     alu_zero;

    always_comb begin
        rs    = ir_q[25:21];
        rt    = ir_q[20:16];
        rd    = ir_q[15:11];
        imm16 = ir_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ir_q <= '0;
        else if (bus.ir_we)
            ir_q <= bus.instr_in;
    end

    always_comb begin
        wr_addr = rd;
        unique case (dst_sel_e'(bus.control_signalDST))
            DST_RD:     wr_addr = rd;
            DST_RT:     wr_addr = rt;
            DST_R31:    wr_addr = REG_LINK;
            DST_RD_ALT: wr_addr = rd;
            default:    wr_addr = rd;
        endcase
    end

    // Register 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (bus.WrEn && (wr_addr != '0)) begin
            regs[wr_addr] <= bus.Dw;
        end
    end

    always_comb begin
        da = (rs == '0) ? '0 : regs[rs];
        db = (rt == '0) ? '0 : regs[rt];
    end

    // Operand latch stage: A/B capture the read ports every edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_p1 <= '0;
            b_p1 <= '0;
        end else begin
            a_p1 <= da;
            b_p1 <= db;
        end
    end

    always_comb begin
        src_a = (alua_sel_e'(bus.control_signalALUa) == ALUA_LATCH) ? a_p1 : bus.pc_in;
        src_b = b_p1;
        unique case (alub_sel_e'(bus.control_signalALUb))
            ALUB_IMM:      src_b = sign_ext16(imm16);
            ALUB_LATCH:    src_b = b_p1;
            ALUB_FOUR:     src_b = CONST_FOUR;
            ALUB_FOUR_ALT: src_b = CONST_FOUR;
            default:       src_b = b_p1;
        endcase
    end

    alu #(.DATA_W(WORD_W)) u_alu (
        .a      (src_a),
        .b      (src_b),
        .cmd    (alu_cmd_e'(bus.command)),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign bus.ALU_out = alu_res;
    assign bus.zero    = alu_zero;

endmodule

// File: tb/tb_ir_registers_alu.sv
// Directed bench for ir_registers_alu with a per-cycle architectural reference model.
module tb_ir_registers_alu;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    ir_registers_alu_if bus ();

    ir_registers_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Architectural state of the reference model
    logic [31:0] m_ir;
    logic [31:0] m_regs [32];
    logic [31:0] m_a, m_b;
    bit          model_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ir = 0; m_a = 0; m_b = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            model_ok = 1;
        end else begin
            int unsigned rs_i, rt_i, rd_i, dst;
            rs_i = m_ir[25:21];
            rt_i = m_ir[20:16];
            rd_i = m_ir[15:11];
            m_a = m_regs[rs_i];
            m_b = m_regs[rt_i];
            if (bus.WrEn) begin
                case (bus.control_signalDST)
                    2'd1:    dst = rt_i;
                    2'd2:    dst = 31;
                    default: dst = rd_i;
                endcase
                if (dst != 0) m_regs[dst] = bus.Dw;
            end
            if (bus.ir_we) m_ir = bus.instr_in;
        end
    end

    function automatic logic [31:0] model_out();
        int a, b;
        logic [15:0] imm;
        imm = m_ir[15:0];
        a = bus.control_signalALUa ? int'(m_a) : int'(bus.pc_in);
        case (bus.control_signalALUb)
            2'd0:    b = int'($signed(imm));
            2'd1:    b = int'(m_b);
            default: b = 4;
        endcase
        case (bus.command)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a & b;
            3'd5: return ~(a & b);
            3'd6: return ~(a | b);
            default: return a | b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (model_ok && rst_n) begin
            logic [31:0] e;
            e = model_out();
            check("cyc_alu_out", bus.ALU_out, e);
            check("cyc_zero", {31'd0, bus.zero}, {31'd0, (e == 32'd0)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_alu(input logic a_sel, input logic [1:0] b_sel, input logic [2:0] cmd);
        bus.control_signalALUa = a_sel;
        bus.control_signalALUb = b_sel;
        bus.command            = cmd;
    endtask

    task automatic load_ir(input logic [31:0] w);
        bus.instr_in = w;
        bus.ir_we    = 1'b1;
        tick();
        bus.ir_we    = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] dst, input logic [31:0] d);
        bus.control_signalDST = dst;
        bus.Dw   = d;
        bus.WrEn = 1'b1;
        tick();
        bus.WrEn = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] v, input logic z);
        #1;
        check({name, "_out"}, bus.ALU_out, v);
        check({name, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
    endtask

    initial begin
        rst_n = 1'b0;
        // Writes asserted during reset must be discarded
        bus.instr_in = 32'hFFFF_FFFF; bus.ir_we = 1'b1;
        bus.Dw = 32'h0000_1234; bus.WrEn = 1'b1; bus.control_signalDST = 2'b10;
        bus.pc_in = 32'd0;
        set_alu(1'b1, 2'b01, 3'b000);
        tick();
        rst_n = 1'b1; bus.ir_we = 1'b0; bus.WrEn = 1'b0;
        expect_out("reset_add", 32'h0000_0000, 1'b1);
        set_alu(1'b0, 2'b00, 3'b000);
        expect_out("reset_ir_imm", 32'h0000_0000, 1'b1);

        bus.pc_in = 32'h003E_0000;
        set_alu(1'b0, 2'b10, 3'b000);
        expect_out("pc_plus4", 32'h003E_0004, 1'b0);

        // Link-register write: latch A lags the write by one edge
        load_ir(32'h03E0_0000);
        write_reg(2'b10, 32'h07C0_0000);
        set_alu(1'b1, 2'b00, 3'b000);
        expect_out("r31_no_bypass", 32'h0000_0000, 1'b1);
        tick();
        expect_out("r31_read", 32'h07C0_0000, 1'b0);

        load_ir(32'h0000_FFFF);
        bus.pc_in = 32'd5;
        set_alu(1'b0, 2'b00, 3'b000);
        expect_out("imm_neg_add", 32'h0000_0004, 1'b0);
        bus.command = 3'b001;
        expect_out("imm_neg_sub", 32'h0000_0006, 1'b0);

        load_ir(32'h0000_0001);
        bus.pc_in = 32'h8000_0000;
        set_alu(1'b0, 2'b00, 3'b011);
        expect_out("slt_overflow", 32'h0000_0001, 1'b0);
        bus.pc_in = 32'd1;
        bus.command = 3'b001;
        expect_out("sub_to_zero", 32'h0000_0000, 1'b1);

        bus.pc_in = 32'h1234_5678;
        set_alu(1'b0, 2'b11, 3'b010);
        expect_out("xor4", 32'h1234_567C, 1'b0);
        bus.command = 3'b100; expect_out("and4", 32'h0000_0000, 1'b1);
        bus.command = 3'b101; expect_out("nand4", 32'hFFFF_FFFF, 1'b0);
        bus.command = 3'b110; expect_out("nor4", 32'hEDCB_A983, 1'b0);
        bus.command = 3'b111; expect_out("or4", 32'h1234_567C, 1'b0);
        bus.command = 3'b011; expect_out("slt_false", 32'h0000_0000, 1'b1);

        // Rd writes through both Rd encodings, then read via Rt on latch B
        load_ir(32'h0060_1800);
        write_reg(2'b00, 32'h0000_0100);
        tick();
        set_alu(1'b1, 2'b00, 3'b000);
        expect_out("rd_write", 32'h0000_1900, 1'b0);
        write_reg(2'b11, 32'h0000_0010);
        tick();
        expect_out("rd_alt_write", 32'h0000_1810, 1'b0);
        load_ir(32'h0003_0000);
        tick();
        set_alu(1'b1, 2'b01, 3'b001);
        expect_out("rt_latch_b", 32'hFFFF_FFF0, 1'b0);

        // Register 0 ignores writes; IR holds when ir_we is low
        load_ir(32'h0000_0000);
        write_reg(2'b01, 32'hFFFF_FFFF);
        tick();
        set_alu(1'b1, 2'b01, 3'b000);
        expect_out("reg0_ignored", 32'h0000_0000, 1'b1);
        bus.instr_in = 32'hFFFF_FFFF;
        tick();
        tick();
        expect_out("ir_hold_regs", 32'h0000_0000, 1'b1);
        bus.pc_in = 32'd0;
        set_alu(1'b0, 2'b00, 3'b000);
        expect_out("ir_hold_imm", 32'h0000_0000, 1'b1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_registers_alu.md
IR_REGISTERS_ALU -- requirements
Module: ir_registers_alu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port instr_in, input, 32 bits: the instruction word to load into the IR.
REQ-004 The block SHALL have port ir_we, input, 1 bit: IR write enable.
REQ-005 The block SHALL have port Dw, input, 32 bits: register-file write data.
REQ-006 The block SHALL have port WrEn, input, 1 bit: register-file write enable.
REQ-007 The block SHALL have port pc_in, input, 32 bits: program counter, an ALU source-A candidate.
REQ-008 The block SHALL have port control_signalDST, input, 2 bits: write-address select; 00 = Rd, 01 = Rt, 10 = constant 31, 11 = Rd.
REQ-009 The block SHALL have port control_signalALUa, input, 1 bit: source-A select; 0 = pc_in, 1 = latch A.
REQ-010 The block SHALL have port control_signalALUb, input, 2 bits: source-B select; 00 = sign-extended imm16, 01 = latch B, 10 = constant 4, 11 = constant 4.
REQ-011 The block SHALL have port command, input, 3 bits: ALU opcode.
REQ-012 The block SHALL have port ALU_out, output, 32 bits: ALU result, combinational.
REQ-013 The block SHALL have port zero, output, 1 bit: 1 iff ALU_out == 0.

Function
REQ-014 The IR SHALL load instr_in on a rising edge when ir_we=1 and SHALL hold its value otherwise.
REQ-015 The IR fields SHALL be: Rs = IR[25:21], Rt = IR[20:16], Rd = IR[15:11], imm16 = IR[15:0].
REQ-016 The register file SHALL hold 32 x 32-bit registers with read ports Da = reg[Rs] and Db = reg[Rt], both combinational.
REQ-017 On a rising edge with WrEn=1, the register file SHALL write Dw to the register selected by control_signalDST.
REQ-018 Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-019 A read of a register written in the same cycle SHALL return the old value; the new value is visible after the edge (no bypass).
REQ-020 Latch A SHALL capture Da and latch B SHALL capture Db on every rising edge, with no enable.
REQ-021 A register value therefore reaches the ALU one edge after the IR load, and one edge after a register-file write.
REQ-022 The sign extension SHALL replicate imm16[15] into bits [31:16].
REQ-023 The ALU command encoding SHALL be: 000 ADD, 001 SUB (A-B), 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
REQ-024 ADD and SUB SHALL wrap modulo 2^32.
REQ-025 SLT SHALL output 32'd1 if A < B as signed numbers, else 0, and SHALL be correct even when A-B overflows.
REQ-026 Carry-out and overflow SHALL be computed internally and not exported.
REQ-027 The ALU path from the source muxes to ALU_out/zero SHALL be purely combinational, with no added latency.

Reset
REQ-028 When rst_n=0 at a rising edge, the IR, latch A, latch B and all 32 registers SHALL clear to 0.
REQ-029 Reset SHALL take priority over ir_we and WrEn; a write asserted during reset is discarded.
REQ-030 After reset with control_signalALUa=1, control_signalALUb=01 and command=ADD, the outputs SHALL be ALU_out=0 and zero=1.

Structure
REQ-031 A shared package SHALL hold the ALU opcode constants, the DST/ALUa/ALUb select encodings, and the constants 31 and 4.
REQ-032 The ALU SHALL be a separate sub-module named alu; the IR, register file, latches, sign-extend and muxes SHALL live in the top module.

Verification
REQ-033 Bench: rst_n=0 for one edge, then ALUa=1, ALUb=01, ADD -> ALU_out=0x00000000, zero=1.
REQ-034 Bench: pc_in=0x003E0000, ALUa=0, ALUb=10, ADD -> ALU_out=0x003E0004, zero=0.
REQ-035 Bench: IR=0x03E00000, DST=10, WrEn=1, Dw=0x07C00000 for one edge, then one more edge, then ALUa=1, ALUb=00, ADD -> ALU_out=0x07C00000.
REQ-036 Bench: IR=0x0000FFFF, pc_in=5, ALUa=0, ALUb=00 -> ADD gives 0x00000004 and SUB gives 0x00000006.
REQ-037 Bench: pc_in=0x80000000, IR imm16=0x0001, SLT -> ALU_out=1; then pc_in=1 with SUB -> ALU_out=0, zero=1.
REQ-038 Bench: write Dw=0xFFFFFFFF to register 0 (DST=01, Rt=0) -> Rs=0 still reads 0; and with ir_we=0 and instr_in changed, the IR fields SHALL remain unchanged.
